// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - operation codes shared by the ALU, its interface and the bench
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_INV  = 3'd5,
    ALU_RSV6 = 3'd6,
    ALU_RSV7 = 3'd7
  } alu_func_e;

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand, operation select, result bus and flag signals of the ALU
interface alu_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0]   operand_a;
  logic [DATA_W-1:0]   operand_b;
  alu_pkg::alu_func_e  alu_func;
  logic                output_enable;
  // A net rather than a variable so the result bus can float when tri-stated.
  wire  [DATA_W-1:0]   alu_result;
  logic                zero_flag;
  logic                positive_flag;
  logic                carry_flag;
  logic                signed_overflow;

  modport master (
    output operand_a,
    output operand_b,
    output alu_func,
    output output_enable,
    input  alu_result,
    input  zero_flag,
    input  positive_flag,
    input  carry_flag,
    input  signed_overflow
  );

  modport slave (
    input  operand_a,
    input  operand_b,
    input  alu_func,
    input  output_enable,
    output alu_result,
    output zero_flag,
    output positive_flag,
    output carry_flag,
    output signed_overflow
  );

endinterface

// File: rtl/alu.sv
// rtl/alu.sv - single-cycle registered ALU with flags; ALU_TRISTATE_EN makes the result bus float when disabled
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0]   wide;
  logic [DATA_W-1:0] next_result;
  logic              next_carry;
  logic              next_ovf;
  logic              next_zero;
  logic              next_pos;
  logic [DATA_W-1:0] result_q;

  always_comb begin
    wide        = '0;
    next_result = '0;
    next_carry  = 1'b0;
    next_ovf    = 1'b0;
    case (bus.alu_func)
      ALU_ADD: begin
        wide        = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
        next_result = wide[MSB:0];
        next_carry  = wide[DATA_W];
        next_ovf    = (bus.operand_a[MSB] == bus.operand_b[MSB]) &&
                      (next_result[MSB] != bus.operand_a[MSB]);
      end
      ALU_SUB: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        wide        = {1'b0, bus.operand_a} - {1'b0, bus.operand_b};
        next_result = wide[MSB:0];
        next_carry  = wide[DATA_W];
        next_ovf    = (bus.operand_a[MSB] != bus.operand_b[MSB]) &&
                      (next_result[MSB] != bus.operand_a[MSB]);
      end
      ALU_AND: next_result = bus.operand_a & bus.operand_b;
      ALU_OR:  next_result = bus.operand_a | bus.operand_b;
      ALU_XOR: next_result = bus.operand_a ^ bus.operand_b;
      ALU_INV: next_result = ~bus.operand_a;
      default: next_result = '0;
    endcase
    next_zero = (next_result == '0);
    next_pos  = !next_zero && !next_result[MSB];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q            <= '0;
      bus.zero_flag       <= 1'b1;
      bus.positive_flag   <= 1'b0;
      bus.carry_flag      <= 1'b0;
      bus.signed_overflow <= 1'b0;
    end else begin
      result_q            <= next_result;
      bus.zero_flag       <= next_zero;
      bus.positive_flag   <= next_pos;
      bus.carry_flag      <= next_carry;
      bus.signed_overflow <= next_ovf;
    end
  end

`ifdef ALU_TRISTATE_EN
  assign bus.alu_result = bus.output_enable ? result_q : {DATA_W{1'bz}};
`else
  assign bus.alu_result = bus.output_enable ? result_q : {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for alu: directed, reset and random vectors against an arithmetic model
module tb_alu;
  import alu_pkg::*;

  localparam int W    = 8;
  localparam int MOD  = 1 << W;
  localparam int HALF = MOD / 2;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         p;
    logic         c;
    logic         o;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   vec_n  = 0;
  exp_t exp_q[$];

  alu_if #(.DATA_W(W)) bus ();

  alu #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int sval(input int v);
    return (v >= HALF) ? v - MOD : v;
  endfunction

  function automatic exp_t model(input logic r, input int a, input int b, input alu_func_e f);
    exp_t e;
    int   s;
    int   ss;
    e = '0;
    s = 0;
    if (r) begin
      e.res = '0;
    end else begin
      case (f)
        ALU_ADD: begin
          s     = a + b;
          ss    = sval(a) + sval(b);
          e.res = W'(s % MOD);
          e.c   = (s >= MOD);
          e.o   = (ss >= HALF) || (ss < -HALF);
        end
        ALU_SUB: begin
          s     = a - b;
          ss    = sval(a) - sval(b);
          e.res = W'((s + MOD) % MOD);
          e.c   = (a < b);
          e.o   = (ss >= HALF) || (ss < -HALF);
        end
        ALU_AND: e.res = W'(a & b);
        ALU_OR:  e.res = W'(a | b);
        ALU_XOR: e.res = W'(a ^ b);
        ALU_INV: e.res = W'((MOD - 1) - a);
        default: e.res = '0;
      endcase
    end
    e.z = (int'(e.res) == 0);
    e.p = (int'(e.res) != 0) && (int'(e.res) < HALF);
    return e;
  endfunction

  task automatic check(input string name, input logic [W+3:0] act, input logic [W+3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got res=%h zpco=%b expected res=%h zpco=%b",
               name, act[W+3:4], act[3:0], req[W+3:4], req[3:0]);
    end
  endtask

  task automatic issue(input logic r, input logic [W-1:0] a, input logic [W-1:0] b, input alu_func_e f);
    rst               = r;
    bus.operand_a     = a;
    bus.operand_b     = b;
    bus.alu_func      = f;
    bus.output_enable = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(r, int'(a), int'(b), f));
    #1;
  endtask

  // Monitor: every registered output is compared half a cycle after the edge that produced it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("vec%0d", vec_n),
              {bus.alu_result, bus.zero_flag, bus.positive_flag, bus.carry_flag, bus.signed_overflow},
              e);
        vec_n++;
      end
    end
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    alu_func_e    rf;

    issue(1'b1, 8'h10, 8'h20, ALU_ADD);

    issue(1'b0, 8'h7F, 8'h01, ALU_ADD);
    issue(1'b0, 8'hFF, 8'h01, ALU_ADD);
    issue(1'b0, 8'h00, 8'h01, ALU_SUB);
    issue(1'b0, 8'h80, 8'h01, ALU_SUB);
    issue(1'b0, 8'h30, 8'h10, ALU_SUB);
    issue(1'b0, 8'hAA, 8'h55, ALU_AND);
    issue(1'b0, 8'hF0, 8'h0F, ALU_OR);
    issue(1'b0, 8'hFF, 8'hFF, ALU_XOR);
    issue(1'b0, 8'hAA, 8'h00, ALU_INV);
    issue(1'b0, 8'h12, 8'h34, ALU_RSV6);
    issue(1'b0, 8'hFF, 8'hFF, ALU_RSV7);

    repeat (3) issue(1'b0, 8'h10, 8'h20, ALU_ADD);
    issue(1'b1, 8'h10, 8'h20, ALU_ADD);
    issue(1'b0, 8'h10, 8'h20, ALU_ADD);

    for (int i = 0; i < 100; i++) begin
      ra = W'($urandom_range(0, MOD - 1));
      rb = W'($urandom_range(0, MOD - 1));
      rf = alu_func_e'($urandom_range(0, 5));
      issue(1'b0, ra, rb, rf);
    end

    // Output enable is combinational: toggle it within one low phase, no new operation.
    issue(1'b0, 8'h55, 8'h55, ALU_ADD);
    @(negedge clk);
    #1;
    check("oe_on_before",
          {bus.alu_result, bus.zero_flag, bus.positive_flag, bus.carry_flag, bus.signed_overflow},
          {8'hAA, 4'b0001});
    bus.output_enable = 1'b0;
    #1;
`ifdef ALU_TRISTATE_EN
    check("oe_off_hiz",
          {bus.alu_result, bus.zero_flag, bus.positive_flag, bus.carry_flag, bus.signed_overflow},
          {{W{1'bz}}, 4'b0001});
`else
    check("oe_off_zero",
          {bus.alu_result, bus.zero_flag, bus.positive_flag, bus.carry_flag, bus.signed_overflow},
          {8'h00, 4'b0001});
`endif
    bus.output_enable = 1'b1;
    #1;
    check("oe_on_after",
          {bus.alu_result, bus.zero_flag, bus.positive_flag, bus.carry_flag, bus.signed_overflow},
          {8'hAA, 4'b0001});

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
